// File: rtl/butterfly2_dif_inv_if.sv
// rtl/butterfly2_dif_inv_if.sv - valid/ready handshake and operand/result bundle for butterfly2_dif_inv
interface butterfly2_dif_inv_if #(
    parameter int N = 16
);
    logic                i_valid;
    logic                o_ready;
    logic signed [N-1:0] i_in0_re;
    logic signed [N-1:0] i_in0_im;
    logic signed [N-1:0] i_in1_re;
    logic signed [N-1:0] i_in1_im;
    logic signed [N-1:0] i_twiddle_re;
    logic signed [N-1:0] i_twiddle_im;
    logic                o_valid;
    logic                i_ready;
    logic signed [N-1:0] o_out0_re;
    logic signed [N-1:0] o_out0_im;
    logic signed [N-1:0] o_out1_re;
    logic signed [N-1:0] o_out1_im;

    modport master (
        output i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
               i_twiddle_re, i_twiddle_im, i_ready,
        input  o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im
    );

    modport slave (
        input  i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
               i_twiddle_re, i_twiddle_im, i_ready,
        output o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im
    );
endinterface

// File: rtl/butterfly2_dif_inv.sv
// rtl/butterfly2_dif_inv.sv - 3-stage radix-2 DIF inverse butterfly; BFLY_INV_ROUND_EN selects round-half-up over truncation
module butterfly2_dif_inv #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int SCALE = 1
) (
    input logic               i_clk,
    input logic               i_rst,
    butterfly2_dif_inv_if.slave bus
);

    localparam int SW  = N + 1;
    localparam int PW  = 2 * N + 2;
    localparam int PSH = Q + SCALE;

    function automatic int rnd_of(input int sh);
        if (sh > 0) return 1 << (sh - 1);
        return 0;
    endfunction

`ifdef BFLY_INV_ROUND_EN
    localparam int PROD_RND = rnd_of(PSH);
    localparam int SUM_RND  = rnd_of(SCALE);
`else
    localparam int PROD_RND = 0;
    localparam int SUM_RND  = 0;
`endif

    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (N - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [N-1:0] sat(input logic signed [PW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[N-1:0];
        if (x < SAT_MIN) return SAT_MIN[N-1:0];
        return x[N-1:0];
    endfunction

    logic                 en;
    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [SW-1:0] sr1_q, sr1_d, si1_q, si1_d, dr1_q, dr1_d, di1_q, di1_d;
    logic signed [N-1:0]  wr1_q, wr1_d, wi1_q, wi1_d;
    logic signed [SW-1:0] sr2_q, sr2_d, si2_q, si2_d;
    logic signed [PW-1:0] prr2_q, prr2_d, pii2_q, pii2_d, pir2_q, pir2_d, pri2_q, pri2_d;
    logic signed [N-1:0]  out0_re_q, out0_re_d, out0_im_q, out0_im_d;
    logic signed [N-1:0]  out1_re_q, out1_re_d, out1_im_q, out1_im_d;
    logic signed [PW-1:0] re_full, im_full, s_re_full, s_im_full;

    always_comb begin
        en = ~v3_q | bus.i_ready;

        // conj(w) folds into the sign pattern: re = dr*wr + di*wi, im = di*wr - dr*wi
        re_full   = prr2_q + pii2_q + PW'(PROD_RND);
        im_full   = pir2_q - pri2_q + PW'(PROD_RND);
        s_re_full = PW'(sr2_q) + PW'(SUM_RND);
        s_im_full = PW'(si2_q) + PW'(SUM_RND);

        v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;
        sr1_d = sr1_q; si1_d = si1_q; dr1_d = dr1_q; di1_d = di1_q;
        wr1_d = wr1_q; wi1_d = wi1_q;
        sr2_d = sr2_q; si2_d = si2_q;
        prr2_d = prr2_q; pii2_d = pii2_q; pir2_d = pir2_q; pri2_d = pri2_q;
        out0_re_d = out0_re_q; out0_im_d = out0_im_q;
        out1_re_d = out1_re_q; out1_im_d = out1_im_q;

        if (en) begin
            v1_d  = bus.i_valid;
            sr1_d = SW'(bus.i_in0_re) + SW'(bus.i_in1_re);
            si1_d = SW'(bus.i_in0_im) + SW'(bus.i_in1_im);
            dr1_d = SW'(bus.i_in0_re) - SW'(bus.i_in1_re);
            di1_d = SW'(bus.i_in0_im) - SW'(bus.i_in1_im);
            wr1_d = bus.i_twiddle_re;
            wi1_d = bus.i_twiddle_im;

            v2_d   = v1_q;
            sr2_d  = sr1_q;
            si2_d  = si1_q;
            prr2_d = PW'(dr1_q) * PW'(wr1_q);
            pii2_d = PW'(di1_q) * PW'(wi1_q);
            pir2_d = PW'(di1_q) * PW'(wr1_q);
            pri2_d = PW'(dr1_q) * PW'(wi1_q);

            v3_d      = v2_q;
            out0_re_d = sat(s_re_full >>> SCALE);
            out0_im_d = sat(s_im_full >>> SCALE);
            out1_re_d = sat(re_full >>> PSH);
            out1_im_d = sat(im_full >>> PSH);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            sr1_q <= '0; si1_q <= '0; dr1_q <= '0; di1_q <= '0;
            wr1_q <= '0; wi1_q <= '0;
            sr2_q <= '0; si2_q <= '0;
            prr2_q <= '0; pii2_q <= '0; pir2_q <= '0; pri2_q <= '0;
            out0_re_q <= '0; out0_im_q <= '0; out1_re_q <= '0; out1_im_q <= '0;
        end else begin
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
            sr1_q <= sr1_d; si1_q <= si1_d; dr1_q <= dr1_d; di1_q <= di1_d;
            wr1_q <= wr1_d; wi1_q <= wi1_d;
            sr2_q <= sr2_d; si2_q <= si2_d;
            prr2_q <= prr2_d; pii2_q <= pii2_d; pir2_q <= pir2_d; pri2_q <= pri2_d;
            out0_re_q <= out0_re_d; out0_im_q <= out0_im_d;
            out1_re_q <= out1_re_d; out1_im_q <= out1_im_d;
        end
    end

    assign bus.o_ready   = en;
    assign bus.o_valid   = v3_q;
    assign bus.o_out0_re = out0_re_q;
    assign bus.o_out0_im = out0_im_q;
    assign bus.o_out1_re = out1_re_q;
    assign bus.o_out1_im = out1_im_q;

endmodule
